bullet_ctrl: RTL and testbench
==============================

// Module: bullet_ctrl
// PURPOSE
//   Player-side bullet controller: the producer of the bullet position consumed by the invader
//   formation block, and the consumer of that block's hit pulse. On a fire request it launches one
//   bullet from the player column, advances it one row up per step tick, and retires it at the top
//   row or on a hit. A cooldown holds off re-fire.
// PARAMETERS
//   STEP_CYCLES      2500  clk cycles per bullet row step (100 us at 25 MHz); minimum 2
//   COOLDOWN_CYCLES  1250  clk cycles spent in COOLDOWN after retire before re-fire is allowed; minimum 1
//   SPAWN_Y          14    row loaded on launch (the row directly above the player row, 15)
// PORTS
//   i_clk_25MHz    in   1  system clock, 25 MHz
//   i_reset        in   1  synchronous, active-high reset
//   i_fire         in   1  fire button, already debounced; level
//   i_player_x     in   5  player column 0..19
//   i_hit          in   1  one-cycle hit pulse from the invader formation
//   o_bullet_x     out  5  bullet column; 0 when parked
//   o_bullet_y     out  4  bullet row; 0 when parked (row 0 never matches a hit)
//   o_active       out  1  1 while a bullet is in flight
//   o_score        out  8  hit count; present only with BULLET_SCORE_EN
// BEHAVIOUR
//   Reset: state=IDLE; o_bullet_x=0; o_bullet_y=0; o_active=0; o_score=0; fire_d=0; counters=0.
//   Fire edge: fire_d registers i_fire; edge = i_fire & ~fire_d. Only a rising edge launches a
//     bullet; holding i_fire never auto-repeats.
//   IDLE: on edge -> FLYING at the next clock edge. o_bullet_x<=i_player_x (latched, not tracked),
//     o_bullet_y<=SPAWN_Y, o_active<=1, step counter<=0. Latency is 1 cycle from the sampled edge.
//   FLYING: step counter counts 0..STEP_CYCLES-1; a step fires on the wrap. Priority per cycle:
//     1. i_hit=1 -> park (x=0, y=0, o_active=0) -> COOLDOWN; o_score+1 if enabled.
//     2. step and o_bullet_y==1 -> park -> COOLDOWN (the bullet left the field; no score).
//     3. step -> o_bullet_y<=o_bullet_y-1.
//     An i_hit coinciding with a step wins, so the bullet does not move that cycle.
//     A fire edge during FLYING or COOLDOWN is dropped, not queued.
//   COOLDOWN: the counter runs COOLDOWN_CYCLES cycles, then -> IDLE. An i_hit arriving here is
//     ignored and not scored (stale pulse).
//   i_hit in IDLE: ignored.
//   i_player_x > 19: latched as given; the column range belongs to the player block.
//   Reset mid-flight: immediate park, IDLE, and the score is cleared.
//   States: 2-bit encoding IDLE=0, FLYING=1, COOLDOWN=2; the value 3 recovers to IDLE with outputs parked.
// CONFIGURATION
//   BULLET_SCORE_EN defined: o_score port exists. It is an 8-bit hit counter that saturates at
//     255 and increments on a scored hit (FLYING and i_hit).
//   BULLET_SCORE_EN undefined: neither the port nor the counter exists. All other behaviour is identical.
// STRUCTURE
//   Shared package invaders_pkg: state encodings, FIELD_COLS=20, PLAYER_ROW=15, PARK_X=0,
//     PARK_Y=0, and the bullet coordinate widths (5/4). The formation block uses the same package.
//   Sub-module bullet_tick_gen: a parameterised cycle counter with synchronous restart and a
//     one-cycle o_tick pulse. There are two instances, one for step timing and one for cooldown
//     timing. Each is restarted on state entry.
// TESTING  (STEP_CYCLES=4, COOLDOWN_CYCLES=3 unless noted)
//   1. Fire with i_player_x=7 and no hit -> o_active=1, x=7, y=14 the cycle after the edge. Then
//      y=13,12,...,1 every 4 cycles, then parked (0,0). o_active=0. IDLE 3 cycles later.
//   2. Launch, then pulse i_hit when y=9 -> park next cycle; o_score 0->1; no further y change.
//   3. Hold i_fire high 200 cycles -> exactly one launch. Release and press during FLYING or
//      COOLDOWN -> no launch. Press after return to IDLE -> launch.
//   4. i_hit in the same cycle as a step at y=5 -> bullet parks from y=5 (y never shows 4);
//      the hit is scored.
//   5. Assert i_reset mid-flight at y=10 with o_score=3 -> next cycle all outputs 0, state IDLE.
//   6. With BULLET_SCORE_EN: 260 hits -> o_score holds at 255. Without the macro the build has no
//      o_score port and tests 1-5 pass unchanged.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared definitions for the invaders playfield: bullet FSM encoding, field geometry and
// the bullet coordinate payload exchanged with the formation block.
package invaders_pkg;

    localparam int unsigned FIELD_COLS = 20;
    localparam int unsigned PLAYER_ROW = 15;
    localparam int unsigned BULLET_X_W = $clog2(FIELD_COLS);
    localparam int unsigned BULLET_Y_W = $clog2(PLAYER_ROW + 1);

    localparam logic [BULLET_X_W-1:0] PARK_X = '0;
    localparam logic [BULLET_Y_W-1:0] PARK_Y = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } bullet_state_e;

    typedef struct packed {
        logic [BULLET_X_W-1:0] x;
        logic [BULLET_Y_W-1:0] y;
    } bullet_pos_t;

endpackage

// File: rtl/bullet_tick_gen.sv
// Cycle counter with synchronous restart; o_tick is high in the cycle the count sits on
// CYCLES-1, i.e. once every CYCLES enabled cycles after a restart.
module bullet_tick_gen #(
    parameter int unsigned CYCLES = 2
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // Tick is registered by looking one count ahead, so it lines up with count_q == LAST.
    always_comb begin
        count_d = count_q;
        if (i_restart) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
        tick_d = (i_restart || i_en) && (count_d == LAST);
    end

    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/bullet_ctrl.sv
// Player bullet controller: launches on a fire edge, climbs one row per step, retires on hit or
// at the top row, then cools down. Define BULLET_SCORE_EN to add the saturating o_score counter.
module bullet_ctrl
    import invaders_pkg::*;
#(
    parameter int unsigned STEP_CYCLES     = 2500,
    parameter int unsigned COOLDOWN_CYCLES = 1250,
    parameter int unsigned SPAWN_Y         = PLAYER_ROW - 1
) (
    input  logic                  i_clk_25MHz,
    input  logic                  i_reset,
    input  logic                  i_fire,
    input  logic [BULLET_X_W-1:0] i_player_x,
    input  logic                  i_hit,
    output logic [BULLET_X_W-1:0] o_bullet_x,
    output logic [BULLET_Y_W-1:0] o_bullet_y,
    output logic                  o_active
`ifdef BULLET_SCORE_EN
    ,
    output logic [7:0]            o_score
`endif
);

    localparam logic [BULLET_Y_W-1:0] SPAWN_ROW = BULLET_Y_W'(SPAWN_Y);
    localparam logic [BULLET_Y_W-1:0] TOP_ROW   = BULLET_Y_W'(1);

    bullet_state_e state_q, state_d;
    bullet_pos_t   pos_q, pos_d;
    logic          active_q, active_d;
    logic          fire_q;
    logic          fire_edge;
    logic          step_restart, cool_restart;
    logic          step_tick, cool_tick;
`ifdef BULLET_SCORE_EN
    logic [7:0]    score_q, score_d;
`endif

    assign fire_edge = i_fire & ~fire_q;

    bullet_tick_gen #(.CYCLES(STEP_CYCLES)) u_step_gen (
        .i_clk_25MHz (i_clk_25MHz),
        .i_reset     (i_reset),
        .i_restart   (step_restart),
        .i_en        (state_q == ST_FLYING),
        .o_tick      (step_tick)
    );

    bullet_tick_gen #(.CYCLES(COOLDOWN_CYCLES)) u_cool_gen (
        .i_clk_25MHz (i_clk_25MHz),
        .i_reset     (i_reset),
        .i_restart   (cool_restart),
        .i_en        (state_q == ST_COOLDOWN),
        .o_tick      (cool_tick)
    );

    // Next state and bullet position; a hit outranks a step in the same cycle.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        active_d     = active_q;
        step_restart = 1'b0;
        cool_restart = 1'b0;
`ifdef BULLET_SCORE_EN
        score_d      = score_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fire_edge) begin
                    state_d      = ST_FLYING;
                    pos_d.x      = i_player_x;
                    pos_d.y      = SPAWN_ROW;
                    active_d     = 1'b1;
                    step_restart = 1'b1;
                end
            end
            ST_FLYING: begin
                if (i_hit) begin
                    state_d      = ST_COOLDOWN;
                    pos_d.x      = PARK_X;
                    pos_d.y      = PARK_Y;
                    active_d     = 1'b0;
                    cool_restart = 1'b1;
`ifdef BULLET_SCORE_EN
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
`endif
                end else if (step_tick) begin
                    if (pos_q.y == TOP_ROW) begin
                        state_d      = ST_COOLDOWN;
                        pos_d.x      = PARK_X;
                        pos_d.y      = PARK_Y;
                        active_d     = 1'b0;
                        cool_restart = 1'b1;
                    end else begin
                        pos_d.y = pos_q.y - BULLET_Y_W'(1);
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cool_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pos_d.x  = PARK_X;
                pos_d.y  = PARK_Y;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            pos_q.x  <= PARK_X;
            pos_q.y  <= PARK_Y;
            active_q <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            active_q <= active_d;
            fire_q   <= i_fire;
        end
    end

`ifdef BULLET_SCORE_EN
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            score_q <= 8'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign o_score = score_q;
`endif

    assign o_bullet_x = pos_q.x;
    assign o_bullet_y = pos_q.y;
    assign o_active   = active_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed and randomized checks of bullet_ctrl against a cycle-level behavioural model
// (STEP_CYCLES=4, COOLDOWN_CYCLES=3); score checks exist only with BULLET_SCORE_EN.
module tb_bullet_ctrl;

    localparam int STEP  = 4;
    localparam int COOL  = 3;
    localparam int SPAWN = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       fire;
    logic       hit;
    logic [4:0] px;
    logic [4:0] o_bullet_x;
    logic [3:0] o_bullet_y;
    logic       o_active;
`ifdef BULLET_SCORE_EN
    logic [7:0] o_score;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0=idle 1=flying 2=cooldown; age = cycles spent in the current mode.
    int m_mode = 0;
    int m_age = 0;
    int m_x = 0;
    int m_y = 0;
    int m_score = 0;
    int m_fire_prev = 0;

    int launches = 0;
    int act_prev = 0;
    int active_cycles = 0;

    always #20 clk = ~clk;

    bullet_ctrl #(
        .STEP_CYCLES     (STEP),
        .COOLDOWN_CYCLES (COOL),
        .SPAWN_Y         (SPAWN)
    ) dut (
        .i_clk_25MHz (clk),
        .i_reset     (rst),
        .i_fire      (fire),
        .i_player_x  (px),
        .i_hit       (hit),
        .o_bullet_x  (o_bullet_x),
        .o_bullet_y  (o_bullet_y),
        .o_active    (o_active)
`ifdef BULLET_SCORE_EN
        ,
        .o_score     (o_score)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic park_model();
        m_x = 0;
        m_y = 0;
        m_mode = 2;
        m_age = 0;
    endtask

    // One clock of the rule set, applied to the inputs sampled at this edge.
    task automatic model_step();
        bit fire_edge;
        bit is_step;
        if (rst) begin
            m_mode = 0; m_age = 0; m_x = 0; m_y = 0; m_score = 0; m_fire_prev = 0;
            return;
        end
        fire_edge = fire && (m_fire_prev == 0);
        m_fire_prev = int'(fire);
        case (m_mode)
            0: if (fire_edge) begin
                m_mode = 1; m_age = 0; m_x = int'(px); m_y = SPAWN;
            end
            1: begin
                is_step = (m_age % STEP) == STEP - 1;
                m_age++;
                if (hit) begin
                    park_model();
                    if (m_score < 255) m_score++;
                end else if (is_step) begin
                    if (m_y == 1) park_model();
                    else m_y--;
                end
            end
            default: begin
                m_age++;
                if (m_age == COOL) begin
                    m_mode = 0; m_age = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("active", int'(o_active), (m_mode == 1) ? 1 : 0);
        chk("bullet_x", int'(o_bullet_x), m_x);
        chk("bullet_y", int'(o_bullet_y), m_y);
`ifdef BULLET_SCORE_EN
        chk("score", int'(o_score), m_score);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (o_active && act_prev == 0) launches++;
        if (o_active) active_cycles++;
        act_prev = int'(o_active);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_row(input string tag, input int row, input bit on_step);
        int guard;
        guard = 0;
        while (!(m_mode == 1 && m_y == row && (!on_step || (m_age % STEP) == STEP - 1))
               && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) chk(tag, m_y, row);
    endtask

    task automatic launch(input int col);
        px = 5'(col);
        fire = 1'b1;
        tick();
        fire = 1'b0;
    endtask

    initial begin
        int l0;
        rst = 1'b1; fire = 1'b0; hit = 1'b0; px = 5'd0;
        run(2);
        rst = 1'b0;
        chk("reset_active", int'(o_active), 0);
        chk("reset_x", int'(o_bullet_x), 0);
        chk("reset_y", int'(o_bullet_y), 0);
        run(2);

        // Free flight from column 7 to the top row, then cooldown.
        active_cycles = 0;
        launch(7);
        chk("launch_x", int'(o_bullet_x), 7);
        chk("launch_y", int'(o_bullet_y), 14);
        chk("launch_active", int'(o_active), 1);
        run(70);
        chk("flight_len", active_cycles, 14 * STEP);
        chk("parked_y", int'(o_bullet_y), 0);

        // Hit at row 9 parks next cycle.
        launch(3);
        wait_row("reach_y9", 9, 1'b0);
        hit = 1'b1; tick(); hit = 1'b0;
        chk("hit_park_y", int'(o_bullet_y), 0);
        chk("hit_park_act", int'(o_active), 0);
        run(8);

        // Held fire gives a single launch; presses in FLYING/COOLDOWN are dropped.
        l0 = launches;
        fire = 1'b1; px = 5'd12;
        run(200);
        fire = 1'b0; tick();
        chk("hold_one_launch", launches - l0, 1);
        launch(4);
        tick();
        fire = 1'b1; tick(); fire = 1'b0; tick();
        hit = 1'b1; tick(); hit = 1'b0;
        fire = 1'b1; tick(); fire = 1'b0; tick();
        run(4);
        chk("drop_presses", launches - l0, 2);
        launch(9);
        chk("relaunch", launches - l0, 3);
        run(3);
        hit = 1'b1; tick(); hit = 1'b0;
        run(COOL + 1);

        // Hit coinciding with the step at row 5 parks from row 5.
        launch(18);
        wait_row("reach_y5_step", 5, 1'b1);
        hit = 1'b1; tick(); hit = 1'b0;
        chk("hit_on_step_y", int'(o_bullet_y), 0);
        run(COOL + 1);

        // Reset mid-flight at row 10 clears everything.
        launch(25);
        wait_row("reach_y10", 10, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_active", int'(o_active), 0);
        chk("midrst_y", int'(o_bullet_y), 0);
        run(2);
        launch(1);
        chk("post_rst_launch", int'(o_active), 1);
        run(2);

        // Randomized soak.
        for (int i = 0; i < 3000; i++) begin
            fire = ($urandom_range(0, 3) == 0);
            hit  = ($urandom_range(0, 9) == 0);
            px   = 5'($urandom_range(0, 31));
            rst  = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; fire = 1'b0; hit = 1'b0;
        run(2);

`ifdef BULLET_SCORE_EN
        // Saturation of the hit counter.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 260; i++) begin
            launch(i % 20);
            tick();
            hit = 1'b1; tick(); hit = 1'b0;
            run(COOL + 1);
        end
        chk("score_sat", int'(o_score), 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
